// File: rtl/flash_writer_pkg.sv
// Shared types, CFI command opcodes and status-register masks for the NOR
// flash program/erase engine.
package flash_writer_pkg;

  localparam int FLASH_AW_DEF = 23;

  typedef logic [FLASH_AW_DEF-1:0] Flash_halfaddr_t;
  typedef logic [FLASH_AW_DEF-2:0] Flash_addr_t;
  typedef logic [15:0]             Flash_data_t;
  typedef logic [31:0]             Word_t;

  localparam Flash_data_t FLASH_CMD_PROGRAM   = 16'h0040;
  localparam Flash_data_t FLASH_CMD_ERASE     = 16'h0020;
  localparam Flash_data_t FLASH_CMD_CONFIRM   = 16'h00D0;
  localparam Flash_data_t FLASH_CMD_STATUS    = 16'h0070;
  localparam Flash_data_t FLASH_CMD_CLRSTAT   = 16'h0050;
  localparam Flash_data_t FLASH_CMD_READARRAY = 16'h00FF;

  // SR.7 = write state machine ready; SR.5/4/3/1 = erase, program, VPP, lock errors
  localparam logic [7:0] SR_READY     = 8'h80;
  localparam logic [7:0] SR_FAIL_MASK = 8'h3A;

  typedef enum logic [2:0] {
    BC_IDLE, BC_SETUP, BC_WE, BC_HOLD, BC_READ
  } bc_state_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_DATA, ST_POLL, ST_CHECK,
    ST_NEXT_HALF, ST_CLEAR, ST_RESTORE, ST_DONE
  } wr_state_t;

  function automatic logic status_ok(input logic [7:0] s);
    return (s & SR_FAIL_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One timed flash bus cycle: a write (setup / we_n low / hold) or a status
// read (oe_n low, sample on last cycle). ack pulses in the cycle ce_n returns high.
module flash_bus_cycle
  import flash_writer_pkg::*;
#(
  parameter int AW           = FLASH_AW_DEF,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 3,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_CYCLES  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_write,
  input  logic [AW-1:0] addr,
  input  Flash_data_t   wdata,
  output logic          ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] flash_a,
  inout  wire  [15:0]   flash_d,
  output logic          flash_ce_n,
  output logic          flash_oe_n,
  output logic          flash_we_n
);

  bc_state_t   st;
  logic [7:0]  cnt;
  logic        drive;
  Flash_data_t dout;

  assign flash_d = drive ? dout : 'z;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= BC_IDLE;
      cnt        <= '0;
      drive      <= 1'b0;
      dout       <= '0;
      ack        <= 1'b0;
      rdata      <= '0;
      flash_a    <= '0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (st)
        BC_IDLE: if (start) begin
          flash_a    <= addr;
          dout       <= wdata;
          flash_ce_n <= 1'b0;
          if (is_write) begin
            drive <= 1'b1;
            cnt   <= 8'(SETUP_CYCLES - 1);
            st    <= BC_SETUP;
          end else begin
            flash_oe_n <= 1'b0;
            cnt        <= 8'(READ_CYCLES - 1);
            st         <= BC_READ;
          end
        end
        BC_SETUP: if (cnt == 8'd0) begin
          flash_we_n <= 1'b0;
          cnt        <= 8'(WE_CYCLES - 1);
          st         <= BC_WE;
        end else cnt <= cnt - 8'd1;
        BC_WE: if (cnt == 8'd0) begin
          flash_we_n <= 1'b1;
          cnt        <= 8'(HOLD_CYCLES - 1);
          st         <= BC_HOLD;
        end else cnt <= cnt - 8'd1;
        BC_HOLD: if (cnt == 8'd0) begin
          flash_ce_n <= 1'b1;
          drive      <= 1'b0;
          ack        <= 1'b1;
          st         <= BC_IDLE;
        end else cnt <= cnt - 8'd1;
        BC_READ: if (cnt == 8'd0) begin
          rdata      <= flash_d[7:0];
          flash_oe_n <= 1'b1;
          flash_ce_n <= 1'b1;
          ack        <= 1'b1;
          st         <= BC_IDLE;
        end else cnt <= cnt - 8'd1;
        default: st <= BC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/flash_writer.sv
// Word program / block erase engine for 16-bit CFI NOR flash; always ends in read-array mode.
// Latency, program with first poll ready: write = SETUP+WE+HOLD+2, read = READ+2 cycles;
// done is high 2*(2*write+read+1)+1+write+1 cycles after the accept edge (51 with defaults).
module flash_writer
  import flash_writer_pkg::*;
#(
  parameter int          FLASH_AW     = FLASH_AW_DEF,
  parameter int          SETUP_CYCLES = 1,
  parameter int          WE_CYCLES    = 3,
  parameter int          HOLD_CYCLES  = 1,
  parameter int          READ_CYCLES  = 4,
  parameter logic [23:0] POLL_LIMIT   = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLASH_AW-2:0] bus_addr,
  input  Word_t               bus_data,
  input  logic                write_op,
  input  logic                erase_op,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          status,
  output logic [FLASH_AW-1:0] flash_a,
  inout  wire  [15:0]         flash_d,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n,
  output logic                flash_rp_n,
  output logic                flash_vpen,
  output logic                flash_byte_n
);

  wr_state_t           st;
  logic                is_erase, half;
  logic [FLASH_AW-2:0] addr_lat;
  Word_t               data_lat;
  logic [23:0]         poll_cnt;
  logic                start, cyc_write, ack;
  logic [FLASH_AW-1:0] cyc_addr;
  Flash_data_t         cyc_data;
  logic [7:0]          rdata;

  assign flash_rp_n   = ~rst;
  assign flash_vpen   = 1'b1;
  assign flash_byte_n = 1'b1;

  flash_bus_cycle #(
    .AW(FLASH_AW), .SETUP_CYCLES(SETUP_CYCLES), .WE_CYCLES(WE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .READ_CYCLES(READ_CYCLES)
  ) u_bus (
    .clk(clk), .rst(rst), .start(start), .is_write(cyc_write),
    .addr(cyc_addr), .wdata(cyc_data), .ack(ack), .rdata(rdata),
    .flash_a(flash_a), .flash_d(flash_d), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      {is_erase, half, busy, done, error, start, cyc_write} <= '0;
      addr_lat <= '0;
      data_lat <= '0;
      poll_cnt <= '0;
      status   <= '0;
      cyc_addr <= '0;
      cyc_data <= '0;
    end else begin
      start <= 1'b0;
      case (st)
        ST_IDLE: if (erase_op || write_op) begin
          is_erase  <= erase_op;
          addr_lat  <= bus_addr;
          data_lat  <= bus_data;
          half      <= 1'b0;
          error     <= 1'b0;
          busy      <= 1'b1;
          cyc_addr  <= {bus_addr, 1'b0};
          cyc_write <= 1'b1;
          cyc_data  <= erase_op ? FLASH_CMD_ERASE : FLASH_CMD_PROGRAM;
          start     <= 1'b1;
          st        <= ST_CMD;
        end
        ST_CMD: if (ack) begin
          cyc_data <= is_erase ? FLASH_CMD_CONFIRM
                    : (half ? data_lat[31:16] : data_lat[15:0]);
          start    <= 1'b1;
          st       <= ST_DATA;
        end
        ST_DATA: if (ack) begin
          cyc_write <= 1'b0;
          poll_cnt  <= '0;
          start     <= 1'b1;
          st        <= ST_POLL;
        end
        ST_POLL: if (ack) begin
          status <= rdata;
          if ((rdata & SR_READY) != 8'h00) begin
            st <= ST_CHECK;
          end else if (poll_cnt + 24'd1 == POLL_LIMIT) begin
            error     <= 1'b1;
            status    <= 8'hFF;
            cyc_write <= 1'b1;
            cyc_data  <= FLASH_CMD_CLRSTAT;
            start     <= 1'b1;
            st        <= ST_CLEAR;
          end else begin
            poll_cnt <= poll_cnt + 24'd1;
            start    <= 1'b1;
          end
        end
        ST_CHECK: begin
          cyc_write <= 1'b1;
          if (!status_ok(status)) begin
            error    <= 1'b1;
            cyc_data <= FLASH_CMD_CLRSTAT;
            start    <= 1'b1;
            st       <= ST_CLEAR;
          end else if (!is_erase && !half) begin
            st <= ST_NEXT_HALF;
          end else begin
            cyc_data <= FLASH_CMD_READARRAY;
            start    <= 1'b1;
            st       <= ST_RESTORE;
          end
        end
        ST_NEXT_HALF: begin
          half     <= 1'b1;
          cyc_addr <= {addr_lat, 1'b1};
          cyc_data <= FLASH_CMD_PROGRAM;
          start    <= 1'b1;
          st       <= ST_CMD;
        end
        ST_CLEAR: if (ack) begin
          cyc_data <= FLASH_CMD_READARRAY;
          start    <= 1'b1;
          st       <= ST_RESTORE;
        end
        ST_RESTORE: if (ack) begin
          done <= 1'b1;
          st   <= ST_DONE;
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer: a small CFI flash model logs every write,
// scripts status-read answers and measures setup / we_n width / hold on each write.
`timescale 1ns/1ps
module tb_flash_writer;
  import flash_writer_pkg::*;

  localparam int AW = 23, SETUP = 1, WE = 3, HOLD = 1, READ = 4;
  localparam logic [22:0] DC = 23'h7FFFFF;   // address don't-care marker

  logic          clk = 1'b0, rst = 1'b1, write_op = 1'b0, erase_op = 1'b0;
  logic [AW-2:0] bus_addr = '0;
  logic [31:0]   bus_data = '0;
  logic          busy, done, error;
  logic [7:0]    status;
  logic [AW-1:0] flash_a;
  wire  [15:0]   flash_d;
  logic          flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_vpen, flash_byte_n;

  flash_writer #(
    .FLASH_AW(AW), .SETUP_CYCLES(SETUP), .WE_CYCLES(WE), .HOLD_CYCLES(HOLD),
    .READ_CYCLES(READ), .POLL_LIMIT(24'd8)
  ) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data(bus_data),
    .write_op(write_op), .erase_op(erase_op), .busy(busy), .done(done),
    .error(error), .status(status), .flash_a(flash_a), .flash_d(flash_d),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
    .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen), .flash_byte_n(flash_byte_n)
  );

  always #12 clk = ~clk;

  int total = 0, bad = 0;
  int reads = 0, wfalls = 0, done_total = 0, timing_viol = 0;
  int ready_after = 1;
  logic [7:0]  ready_val = 8'h80;
  logic [15:0] mem [int];
  logic [38:0] wlog [$];
  logic [7:0]  pending = 8'h00;

  // Undriven bus floats high so a released flash_d is observable.
  pullup (flash_d);
  assign flash_d = (!flash_oe_n && !flash_ce_n)
                 ? ((reads >= ready_after) ? {8'h00, ready_val} : 16'h0000) : 16'hzzzz;

  logic          prev_we = 1'b1, prev_oe = 1'b1, prev_ce = 1'b1, in_hold = 1'b0;
  logic [AW-1:0] prev_a = '0, hold_a = '0;
  logic [15:0]   prev_d = '0;
  int            run = 0, we_low = 0, hold_cnt = 0;

  always @(negedge clk) begin
    if (done) done_total++;
    if (rst) begin
      run = 0; we_low = 0; in_hold = 1'b0;
    end else begin
      if (!flash_ce_n && !prev_ce && flash_a == prev_a && flash_d == prev_d) run++;
      else run = flash_ce_n ? 0 : 1;
      if (in_hold) begin
        if (!flash_ce_n && flash_we_n && flash_a == hold_a) hold_cnt++;
        else begin
          if (hold_cnt < HOLD) timing_viol++;
          in_hold = 1'b0;
        end
      end
      if (prev_we && !flash_we_n) begin
        wfalls++;
        we_low = 1;
        if (run - 1 < SETUP) timing_viol++;
      end else if (!flash_we_n) begin
        we_low++;
      end else if (!prev_we) begin
        if (we_low != WE) timing_viol++;
        if (flash_ce_n) timing_viol++;
        else begin
          wlog.push_back({flash_a, flash_d});
          if (pending == 8'h40) begin
            mem[int'(flash_a)] = flash_d;
            pending = 8'h00;
          end else if (flash_d == 16'h0040 || flash_d == 16'h0020) pending = flash_d[7:0];
          else pending = 8'h00;
          in_hold = 1'b1; hold_cnt = 1; hold_a = flash_a;
        end
      end
      if (prev_oe && !flash_oe_n && !flash_ce_n) reads++;
    end
    prev_we = flash_we_n; prev_oe = flash_oe_n; prev_ce = flash_ce_n;
    prev_a = flash_a; prev_d = flash_d;
  end

  logic busy_at_accept, err_at_accept, seen, busy_after;

  task automatic clear_model(input int ra, input logic [7:0] rv);
    wlog.delete(); mem.delete();
    reads = 0; pending = 8'h00; ready_after = ra; ready_val = rv;
  endtask

  task automatic start_op(input logic w, input logic e, input logic [AW-2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    write_op = w; erase_op = e; bus_addr = a; bus_data = d;
    @(posedge clk); #1;
    write_op = 1'b0; erase_op = 1'b0;
    @(negedge clk);
    busy_at_accept = busy; err_at_accept = error;
  endtask

  task automatic wait_done();
    seen = 1'b0; busy_after = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (seen) begin busy_after = busy; break; end
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen || busy_after !== 1'b0) begin
      bad++; $display("FAIL done_then_idle: done_seen=%0b busy_after=%0b want 1/0", seen, busy_after);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, error}); end
    total++; if (status !== 8'h00) begin bad++; $display("FAIL rst_status: got %h want 00", status); end
    total++; if ({flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n} !== 4'b1110) begin
      bad++; $display("FAIL rst_ctl: got %b want 1110", {flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n}); end
    total++; if (flash_a !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", flash_a); end
    total++; if (flash_d !== 16'hFFFF) begin bad++; $display("FAIL rst_data_released: got %h want FFFF", flash_d); end
    total++; if ({flash_vpen, flash_byte_n} !== 2'b11) begin bad++; $display("FAIL rst_vpen_byte: got %b want 11", {flash_vpen, flash_byte_n}); end
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (flash_rp_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release: rp_n=%b busy=%b want 1/0", flash_rp_n, busy); end
  endtask

  task automatic test_program();
    logic [15:0] ed [5] = '{16'h0040, 16'hBEEF, 16'h0040, 16'hDEAD, 16'h00FF};
    logic [22:0] ea [5] = '{23'h20, 23'h20, 23'h21, 23'h21, DC};
    int d0 = done_total;
    clear_model(1, 8'h80);
    start_op(1'b1, 1'b0, 22'h000010, 32'hDEADBEEF);
    total++; if (busy_at_accept !== 1'b1) begin bad++; $display("FAIL prog_busy_rise: got %b want 1", busy_at_accept); end
    wait_done();
    total++; if (wlog.size() != 5) begin bad++; $display("FAIL prog_nwrites: got %0d want 5", wlog.size()); end
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i][15:0] !== ed[i] || (ea[i] != DC && wlog[i][38:16] !== ea[i])) begin
        bad++; $display("FAIL prog_write%0d: got %h@%h want %h@%h", i, wlog[i][15:0], wlog[i][38:16], ed[i], ea[i]); end
    end
    total++; if (error !== 1'b0 || status !== 8'h80) begin bad++; $display("FAIL prog_result: error=%b status=%h want 0/80", error, status); end
    total++; if (mem[32'h20] !== 16'hBEEF || mem[32'h21] !== 16'hDEAD) begin
      bad++; $display("FAIL prog_array: got %h %h want BEEF DEAD", mem[32'h20], mem[32'h21]); end
    total++; if (reads != 2 || done_total - d0 != 1) begin bad++; $display("FAIL prog_counts: reads=%0d dones=%0d want 2/1", reads, done_total - d0); end
    total++; if (timing_viol != 0) begin bad++; $display("FAIL prog_timing: violations=%0d want 0", timing_viol); end
  endtask

  task automatic test_erase();
    logic [15:0] ed [3] = '{16'h0020, 16'h00D0, 16'h00FF};
    logic [22:0] ea [3] = '{23'h10000, 23'h10000, DC};
    int d0 = done_total;
    clear_model(6, 8'h80);
    start_op(1'b0, 1'b1, 22'h008000, 32'h0);
    wait_done();
    total++; if (wlog.size() != 3) begin bad++; $display("FAIL erase_nwrites: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i][15:0] !== ed[i] || (ea[i] != DC && wlog[i][38:16] !== ea[i])) begin
        bad++; $display("FAIL erase_write%0d: got %h@%h want %h@%h", i, wlog[i][15:0], wlog[i][38:16], ed[i], ea[i]); end
    end
    total++; if (reads != 6) begin bad++; $display("FAIL erase_reads: got %0d want 6", reads); end
    total++; if (error !== 1'b0 || status !== 8'h80 || done_total - d0 != 1) begin
      bad++; $display("FAIL erase_result: error=%b status=%h dones=%0d want 0/80/1", error, status, done_total - d0); end
    total++; if (timing_viol != 0) begin bad++; $display("FAIL erase_timing: violations=%0d want 0", timing_viol); end
  endtask

  task automatic test_program_error();
    logic [15:0] ed [4] = '{16'h0040, 16'h5678, 16'h0050, 16'h00FF};
    clear_model(1, 8'h90);
    start_op(1'b1, 1'b0, 22'h000010, 32'h12345678);
    wait_done();
    total++; if (wlog.size() != 4) begin bad++; $display("FAIL perr_nwrites: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i][15:0] !== ed[i]) begin bad++; $display("FAIL perr_write%0d: got %h want %h", i, wlog[i][15:0], ed[i]); end
    end
    total++; if (error !== 1'b1 || status !== 8'h90) begin bad++; $display("FAIL perr_result: error=%b status=%h want 1/90", error, status); end
    total++; if (mem.exists(32'h21) || reads != 1) begin bad++; $display("FAIL perr_no_high_half: high_written=%0b reads=%0d want 0/1", mem.exists(32'h21), reads); end
  endtask

  task automatic test_timeout();
    logic [15:0] ed [4] = '{16'h0040, 16'h1111, 16'h0050, 16'h00FF};
    int d0 = done_total;
    clear_model(1000, 8'h80);
    start_op(1'b1, 1'b0, 22'h000004, 32'h22221111);
    wait_done();
    total++; if (reads != 8) begin bad++; $display("FAIL tmo_reads: got %0d want 8", reads); end
    total++; if (error !== 1'b1 || status !== 8'hFF || done_total - d0 != 1) begin
      bad++; $display("FAIL tmo_result: error=%b status=%h dones=%0d want 1/FF/1", error, status, done_total - d0); end
    total++; if (wlog.size() != 4) begin bad++; $display("FAIL tmo_nwrites: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i][15:0] !== ed[i]) begin bad++; $display("FAIL tmo_write%0d: got %h want %h", i, wlog[i][15:0], ed[i]); end
    end
  endtask

  task automatic test_collision();
    logic [15:0] ed [3] = '{16'h0020, 16'h00D0, 16'h00FF};
    int d0 = done_total;
    clear_model(1, 8'h80);
    start_op(1'b1, 1'b1, 22'h000100, 32'hCAFE0001);
    total++; if (err_at_accept !== 1'b0) begin bad++; $display("FAIL coll_error_clear: got %b want 0", err_at_accept); end
    repeat (10) @(negedge clk);
    #1 write_op = 1'b1; bus_addr = 22'h000033;
    @(negedge clk); #1 write_op = 1'b0;
    wait_done();
    repeat (80) @(negedge clk);
    total++; if (wlog.size() != 3) begin bad++; $display("FAIL coll_nwrites: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i][15:0] !== ed[i] || (i < 2 && wlog[i][38:16] !== 23'h200)) begin
        bad++; $display("FAIL coll_write%0d: got %h@%h want %h@200", i, wlog[i][15:0], wlog[i][38:16], ed[i]); end
    end
    total++; if (done_total - d0 != 1 || busy !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL coll_result: dones=%0d busy=%b error=%b want 1/0/0", done_total - d0, busy, error); end
  endtask

  task automatic test_reset_mid();
    int w0 = wfalls, n0;
    logic hit = 1'b0;
    clear_model(1, 8'h80);
    start_op(1'b1, 1'b0, 22'h000010, 32'hDEADBEEF);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (wfalls - w0 == 2 && !flash_we_n) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach_data_we: got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({flash_we_n, flash_ce_n, flash_oe_n, busy, done} !== 5'b11100) begin
      bad++; $display("FAIL rmid_pins: we,ce,oe,busy,done=%b want 11100", {flash_we_n, flash_ce_n, flash_oe_n, busy, done}); end
    total++; if (flash_d !== 16'hFFFF) begin bad++; $display("FAIL rmid_data_released: got %h want FFFF", flash_d); end
    n0 = wlog.size();
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (wlog.size() != n0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_no_recovery: new_writes=%0d busy=%b want 0/0", wlog.size() - n0, busy); end
    clear_model(1, 8'h80);
    start_op(1'b1, 1'b0, 22'h000040, 32'h0BAD0F00);
    wait_done();
    total++; if (mem[32'h80] !== 16'h0F00 || mem[32'h81] !== 16'h0BAD || error !== 1'b0) begin
      bad++; $display("FAIL rmid_after: got %h %h err=%b want 0F00 0BAD 0", mem[32'h80], mem[32'h81], error); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_erase();
    test_program_error();
    test_timeout();
    test_collision();
    test_reset_mid();
    total++; if (timing_viol != 0) begin bad++; $display("FAIL final_timing: violations=%0d want 0", timing_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_writer.md
Name: flash_writer

Overview:
- Write-side counterpart of the flash read path: programs 32-bit words and erases blocks in the on-board 16-bit Intel/CFI NOR flash (JS28F640-class) on behalf of the system bus.
- Issues command sequences (program 0x40, block erase 0x20/0xD0), polls the status register (0x70 mode), clears status (0x50) and always returns the device to read-array mode (0xFF).
- This lets the existing read path resume with no extra handling.
- Sits beside the flash read controller behind the flash pin mux; owns the pins while busy=1.

Parameters:
- FLASH_AW, 23, flash halfword address width (flash_a)
- SETUP_CYCLES, 1, clk cycles address/data stable before flash_we_n falls
- WE_CYCLES, 3, clk cycles flash_we_n held low (≥75 ns at 40 MHz)
- HOLD_CYCLES, 1, clk cycles after flash_we_n rises before the bus changes
- READ_CYCLES, 4, clk cycles flash_oe_n low before status is sampled
- POLL_LIMIT, 24'hFFFFFF, maximum status reads before timeout

Ports:
- clk  in  1  system clock, 40 MHz
- rst  in  1  synchronous active-high reset
- bus_addr  in  Flash_addr_t  word address; halfword address = {bus_addr,1'b0} (low half) and {bus_addr,1'b1} (high half)
- bus_data  in  Word_t  data to program
- write_op  in  1  start a word program; sampled in IDLE only
- erase_op  in  1  start a block erase of the block containing {bus_addr,1'b0}; sampled in IDLE only
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at completion (success or error)
- error  out  1  sticky until the next accepted op; status error or timeout
- status  out  8  last status byte read
- flash_a  out  FLASH_AW  halfword address
- flash_d  inout  16  data; driven only during write cycles, else high-Z
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each  active-low controls
- flash_rp_n, flash_vpen, flash_byte_n  out  1 each  reset/program-enable/word mode

Behaviour:
- Reset values:
  - busy=0, done=0, error=0, status=0
  - flash_ce_n=1, flash_oe_n=1, flash_we_n=1, flash_rp_n=0 while rst, 1 after
  - flash_vpen=1, flash_byte_n=1, flash_a=0, flash_d=Z
  - FSM=IDLE
- Reset mid-operation: all pins return to reset values in the next cycle; no recovery sequence is issued.
- Start:
  - In IDLE, erase_op has priority over write_op; both asserted starts an erase.
  - Ops asserted while busy=1 are ignored.
  - busy rises the cycle after acceptance; address/data are latched at acceptance.
- Write bus cycle: drive flash_a/flash_d and ce_n=0.
  - SETUP_CYCLES later, we_n=0 for WE_CYCLES.
  - we_n=1, HOLD_CYCLES later ce_n=1 and flash_d=Z.
- Read bus cycle: ce_n=0, oe_n=0 for READ_CYCLES; sample flash_d[7:0] into status on the last cycle; then oe_n=1, ce_n=1.
- FSM: IDLE -> CMD -> DATA -> POLL -> CHECK -> (NEXT_HALF -> CMD) | CLEAR -> RESTORE -> DONE -> IDLE.
  - CMD writes 0x40 (program) or 0x20 (erase).
  - DATA writes the halfword data, or 0xD0 for erase.
  - POLL performs a read cycle and repeats until status[7]=1.
  - CHECK passes if status[5:3]==0 and status[1]==0.
- Program sequence:
  - The low halfword bus_data[15:0] goes to address ...0.
  - Then NEXT_HALF programs the high halfword bus_data[31:16] to address ...1.
  - Erase does one pass only.
- Error:
  - CHECK failure sets error=1, skips the remaining half, and goes to CLEAR (write 0x50).
  - The POLL counter reaching POLL_LIMIT sets error=1 and status=8'hFF, then goes to CLEAR.
- RESTORE always writes 0xFF. DONE pulses done for exactly 1 cycle with busy=1; busy falls the following cycle.
- error clears when the next op is accepted. status holds until the next status read.
- Latency, program with first poll ready:
  - Each write cycle takes SETUP+WE+HOLD+1 cycles.
  - 2×(2 writes + 1 read) + RESTORE + DONE.
  - Exact count is implementation-fixed and documented in a header comment; the bench checks ordering, not exact count.

Decomposition:
- defines.svh additions:
  - Flash_halfaddr_t (FLASH_AW bits), Flash_data_t (16 bits)
  - FLASH_CMD_PROGRAM=0x40, FLASH_CMD_ERASE=0x20, FLASH_CMD_CONFIRM=0xD0, FLASH_CMD_STATUS=0x70, FLASH_CMD_CLRSTAT=0x50, FLASH_CMD_READARRAY=0xFF
  - status bit masks
- Sub-module flash_bus_cycle:
  - Performs one timed read or write cycle.
  - start/is_write/addr/wdata in; ack/rdata out; owns the pins and the timing counters.
- flash_writer holds the command FSM and poll counter.

Test Plan:
- Program: bench flash model returns status 0x80 immediately; bus_addr=22'h000010, bus_data=32'hDEADBEEF. Required pin writes in order:
  - 0x40@0x20, 0xBEEF@0x20, 0x40@0x21, 0xDEAD@0x21, 0xFF
  - then error=0, one done pulse, and model array[0x20]=BEEF, [0x21]=DEAD.
- Erase: bus_addr=22'h008000 -> writes 0x20@0x10000, then 0xD0@0x10000. Model returns 0x00 ×5, then 0x80 -> exactly 6 status reads, 0xFF restore, done, error=0.
- Program error: model returns 0x90 on the first poll -> no high-half program, 0x50 then 0xFF written, error=1, status=0x90.
- Timeout: POLL_LIMIT=8, model never ready -> 8 reads, status=0xFF, error=1, 0x50/0xFF issued, done pulse.
- Collisions:
  - write_op=erase_op=1 in IDLE -> erase sequence.
  - write_op pulsed while busy -> ignored, no extra done.
  - A new op after an error clears error.
- Reset mid-WE_CYCLES of the DATA cycle -> next cycle we_n=1, ce_n=1, flash_d=Z, busy=0.
- Timing check on every write: we_n low exactly WE_CYCLES; address stable ≥SETUP before the we_n fall and ≥HOLD after the rise.
